// File: rtl/sipo_deserializer_if.sv
// Bundle between the serial source / word consumer and sipo_deserializer.
// Serial side: serial_in, serial_valid, frame_start. Word side:
// parallel_out, out_valid, out_ready. Status: busy, overrun, framing_err.
interface sipo_deserializer_if #(
   parameter int WIDTH = 3
);
   logic             serial_in;
   logic             serial_valid;
   logic             frame_start;
   logic [WIDTH-1:0] parallel_out;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             overrun;
   logic             framing_err;

   modport master (
      output serial_in, serial_valid, frame_start, out_ready,
      input  parallel_out, out_valid, busy, overrun, framing_err
   );

   modport slave (
      input  serial_in, serial_valid, frame_start, out_ready,
      output parallel_out, out_valid, busy, overrun, framing_err
   );
endinterface

// File: rtl/sipo_deserializer.sv
// Framed serial-in parallel-out deserializer with one-word output register.
// Ports: clk, reset (sync, active-high), bus (sipo_deserializer_if.slave).
module sipo_deserializer #(
   parameter int WIDTH     = 3,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   sipo_deserializer_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] sreg, sreg_n;
   logic [WIDTH-1:0] dout, dout_n;
   logic             oval, oval_n;
   logic             ovr, ovr_n;
   logic             ferr, ferr_n;
   logic [WIDTH-1:0] word;

   // Bit position for the c-th received bit of a word.
   function automatic int pos(input int c);
      return MSB_FIRST ? (WIDTH - 1 - c) : c;
   endfunction

   function automatic logic [WIDTH-1:0] put(
      input logic [WIDTH-1:0] w,
      input int               p,
      input logic             b
   );
      logic [WIDTH-1:0] r;
      r = w;
      for (int i = 0; i < WIDTH; i++)
         if (i == p) r[i] = b;
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         sreg  <= '0;
         dout  <= '0;
         oval  <= 1'b0;
         ovr   <= 1'b0;
         ferr  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         sreg  <= sreg_n;
         dout  <= dout_n;
         oval  <= oval_n;
         ovr   <= ovr_n;
         ferr  <= ferr_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sreg_n  = sreg;
      dout_n  = dout;
      oval_n  = oval;
      ovr_n   = ovr;
      ferr_n  = ferr;
      word    = put(sreg, pos(int'(cnt)), bus.serial_in);

      if (oval && bus.out_ready)
         oval_n = 1'b0;

      if (bus.serial_valid) begin
         unique case (state)
            IDLE: begin
               if (bus.frame_start) begin
                  sreg_n  = put('0, pos(0), bus.serial_in);
                  cnt_n   = CW'(1);
                  state_n = SHIFT;
               end
            end
            SHIFT: begin
               if (bus.frame_start) begin
                  // Restart wins even on what would be the last bit.
                  ferr_n = 1'b1;
                  sreg_n = put('0, pos(0), bus.serial_in);
                  cnt_n  = CW'(1);
               end else if (cnt == CW'(WIDTH - 1)) begin
                  state_n = IDLE;
                  cnt_n   = '0;
                  sreg_n  = '0;
                  // Slot is free if empty or being drained this cycle.
                  if (!oval || bus.out_ready) begin
                     dout_n = word;
                     oval_n = 1'b1;
                  end else begin
                     ovr_n = 1'b1;
                  end
               end else begin
                  sreg_n = word;
                  cnt_n  = cnt + CW'(1);
               end
            end
         endcase
      end
   end

   assign bus.parallel_out = dout;
   assign bus.out_valid    = oval;
   assign bus.busy         = (state == SHIFT);
   assign bus.overrun      = ovr;
   assign bus.framing_err  = ferr;
endmodule
